// File: rtl/data_cache.sv
// Direct-mapped, write-back data cache: 8-bit CPU load/store port in front of
// a 32-bit block memory. Hits are serviced with zero stall; misses stall the
// CPU, write back a dirty victim if needed, then refill the block.
module data_cache #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int unsigned TAG_BITS   = 6 - INDEX_BITS;
  localparam int unsigned NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t state;

  // Storage arrays; data and tags are never cleared, only valid/dirty are.
  logic [31:0]           data_q [NUM_BLOCKS];
  logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  // Miss context captured in IDLE so later CPU changes cannot disturb it.
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;

  // Set on entry to a memory-request state so that edge's MEM_BUSYWAIT is ignored.
  logic entry_q;

  logic        mem_read_q;
  logic        mem_write_q;
  logic [5:0]  mem_address_q;
  logic [31:0] mem_writedata_q;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [1:0]            addr_offset;
  logic [31:0]           sel_block;
  logic [7:0]            sel_byte;
  logic                  in_idle;
  logic                  access;
  logic                  load;
  logic                  store;
  logic                  hit;
  logic                  miss;
  logic                  store_hit;
  logic                  victim_dirty;
  logic                  fill;
  logic                  mem_done;

  // Address split and lookup.
  assign addr_tag     = ADDRESS[7:2+INDEX_BITS];
  assign addr_index   = ADDRESS[1+INDEX_BITS:2];
  assign addr_offset  = ADDRESS[1:0];
  assign sel_block    = data_q[addr_index];
  assign sel_byte     = sel_block[{addr_offset, 3'b000} +: 8];

  // Simultaneous READ and WRITE is treated as no request at all.
  assign in_idle      = (state == IDLE);
  assign access       = READ ^ WRITE;
  assign load         = READ & ~WRITE;
  assign store        = WRITE & ~READ;
  assign hit          = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign miss         = access && !hit;
  assign store_hit    = in_idle && store && hit;
  assign victim_dirty = valid_q[addr_index] && dirty_q[addr_index];
  assign fill         = (state == UPDATE);
  assign mem_done     = !entry_q && !MEM_BUSYWAIT;

  // CPU-facing outputs: hits answer combinationally, anything outside IDLE stalls.
  assign BUSYWAIT      = in_idle ? miss : 1'b1;
  assign READDATA      = (in_idle && load && hit) ? sel_byte : 8'h00;

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

  // Data and tag arrays: byte writes on store hits, whole-block refill in UPDATE.
  always_ff @(posedge CLK) begin
    if (store_hit) begin
      data_q[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
    end
    if (fill) begin
      data_q[req_index] <= MEM_READDATA;
      tag_q[req_index]  <= req_tag;
    end
  end

  // Miss-handling FSM with registered memory-side outputs and valid/dirty bookkeeping.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      req_tag         <= '0;
      req_index       <= '0;
      entry_q         <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            req_tag   <= addr_tag;
            req_index <= addr_index;
            entry_q   <= 1'b1;
            if (victim_dirty) begin
              state           <= WRITEBACK;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {tag_q[addr_index], addr_index};
              mem_writedata_q <= sel_block;
            end else begin
              state         <= FETCH;
              mem_read_q    <= 1'b1;
              mem_address_q <= {addr_tag, addr_index};
            end
          end else if (store_hit) begin
            dirty_q[addr_index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          entry_q <= 1'b0;
          if (mem_done) begin
            state           <= FETCH;
            entry_q         <= 1'b1;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
            mem_read_q      <= 1'b1;
            mem_address_q   <= {req_tag, req_index};
          end
        end
        FETCH: begin
          entry_q <= 1'b0;
          if (mem_done) begin
            state         <= UPDATE;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
          end
        end
        UPDATE: begin
          state              <= IDLE;
          valid_q[req_index] <= 1'b1;
          dirty_q[req_index] <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The memory side must never see a read and a write request together.
  assert property (@(posedge CLK) disable iff (RESET) !(MEM_READ && MEM_WRITE));

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: a block-level reference model of the cache contents
// and miss sequence, a latency-configurable memory, per-cycle output
// comparison, and directed scenarios with literal expectations.
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  data_cache dut (
    .CLK(CLK),
    .RESET(RESET),
    .READ(READ),
    .WRITE(WRITE),
    .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
  endtask

  // Main memory: 64 blocks, answering after mem_lat busy cycles.
  logic [31:0] mem [64];
  int mem_lat    = 1;
  int mem_cnt    = 0;
  int mem_served = 0;
  bit mem_ready  = 1'b0;

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b + 8'h30, b + 8'h20, b + 8'h10, b};
  endfunction

  always @(posedge CLK or posedge RESET) begin : memory
    int kind;
    if (RESET) begin
      MEM_BUSYWAIT <= 1'b0;
      mem_cnt      <= 0;
      mem_served   <= 0;
      if (!mem_ready) begin
        for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        mem[1]    <= 32'hDDCCBBAA;
        mem[9]    <= 32'h44332211;
        mem_ready <= 1'b1;
      end
    end else begin
      kind = MEM_WRITE ? 1 : (MEM_READ ? 2 : 0);
      if (kind == 0) begin
        MEM_BUSYWAIT <= 1'b0;
        mem_cnt      <= 0;
        mem_served   <= 0;
      end else if (kind != mem_served) begin
        if (mem_cnt < mem_lat) begin
          MEM_BUSYWAIT <= 1'b1;
          mem_cnt      <= mem_cnt + 1;
        end else begin
          MEM_BUSYWAIT <= 1'b0;
          mem_cnt      <= 0;
          mem_served   <= kind;
          if (kind == 1) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          else           MEM_READDATA     <= mem[MEM_ADDRESS];
        end
      end
    end
  end

  // Reference model: cache contents per block plus which phase of a miss is in progress.
  // phase 0 = servicing CPU, 1 = writing victim out, 2 = reading block in, 3 = installing block.
  bit          m_valid [8];
  bit          m_dirty [8];
  int          m_tag   [8];
  logic [31:0] m_blk   [8];
  int          m_phase = 0;
  int          m_age   = 0;
  int          m_rtag  = 0;
  int          m_ridx  = 0;

  always @(posedge CLK or posedge RESET) begin : model
    int idx, tg, off;
    bit acc, hit;
    if (RESET) begin
      m_phase = 0;
      m_age   = 0;
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
    end else begin
      idx = (int'(ADDRESS) / 4) % 8;
      tg  = int'(ADDRESS) / 32;
      off = int'(ADDRESS) % 4;
      acc = (READ != WRITE);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      case (m_phase)
        0: begin
          if (acc && !hit) begin
            m_rtag  = tg;
            m_ridx  = idx;
            m_age   = 0;
            m_phase = (m_valid[idx] && m_dirty[idx]) ? 1 : 2;
          end else if (WRITE && !READ && hit) begin
            m_blk[idx][off*8 +: 8] = WRITEDATA;
            m_dirty[idx] = 1'b1;
          end
        end
        1, 2: begin
          // A memory phase lasts at least two cycles and ends once memory is idle.
          if (m_age >= 1 && !MEM_BUSYWAIT) begin
            m_phase = m_phase + 1;
            m_age   = 0;
          end else begin
            m_age++;
          end
        end
        default: begin
          m_blk[m_ridx]   = mem[m_rtag * 8 + m_ridx];
          m_tag[m_ridx]   = m_rtag;
          m_valid[m_ridx] = 1'b1;
          m_dirty[m_ridx] = 1'b0;
          m_phase         = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge CLK) begin : compare
    int idx, tg, off;
    bit acc, hit, exp_busy;
    logic [7:0] exp_rd;
    logic [5:0] exp_ma;
    if (started) begin
      idx = (int'(ADDRESS) / 4) % 8;
      tg  = int'(ADDRESS) / 32;
      off = int'(ADDRESS) % 4;
      acc = (READ != WRITE);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      exp_busy = (m_phase != 0) || (acc && !hit);
      exp_rd   = (m_phase == 0 && READ && !WRITE && hit) ? 8'(m_blk[idx] >> (off * 8)) : 8'h00;
      exp_ma   = (m_phase == 1) ? 6'(m_tag[m_ridx] * 8 + m_ridx) :
                 (m_phase == 2) ? 6'(m_rtag * 8 + m_ridx) : 6'd0;
      chk("cmp_busywait",    32'(BUSYWAIT),    32'(exp_busy));
      chk("cmp_readdata",    32'(READDATA),    32'(exp_rd));
      chk("cmp_mem_read",    32'(MEM_READ),    32'(m_phase == 2));
      chk("cmp_mem_write",   32'(MEM_WRITE),   32'(m_phase == 1));
      chk("cmp_mem_address", 32'(MEM_ADDRESS), 32'(exp_ma));
      if (m_phase == 1) chk("cmp_mem_writedata", MEM_WRITEDATA, m_blk[m_ridx]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    READ      = r;
    WRITE     = w;
    ADDRESS   = a;
    WRITEDATA = d;
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (BUSYWAIT && n < 50) begin
      step();
      n++;
    end
    chk({name, "_ready"}, 32'(BUSYWAIT), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    #2;
    RESET   = 1'b1;
    started = 1'b1;
    step();
    step();
    chk("reset_busywait",    32'(BUSYWAIT),    32'd0);
    chk("reset_mem_read",    32'(MEM_READ),    32'd0);
    chk("reset_mem_write",   32'(MEM_WRITE),   32'd0);
    chk("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("reset_readdata",    32'(READDATA),    32'd0);
    RESET = 1'b0;
    step();

    // Clean read miss at 0x05.
    drive(1'b1, 1'b0, 8'h05, 8'h00);
    #1;
    chk("miss_busywait", 32'(BUSYWAIT), 32'd1);
    step();
    chk("fetch_mem_read",    32'(MEM_READ),    32'd1);
    chk("fetch_mem_write",   32'(MEM_WRITE),   32'd0);
    chk("fetch_mem_address", 32'(MEM_ADDRESS), 32'h01);
    wait_ready("read_05", n);
    chk("clean_miss_stall", 32'(n + 1), 32'd5);
    chk("read_05_data", 32'(READDATA), 32'hBB);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Write hit at 0x06, then read it back.
    drive(1'b0, 1'b1, 8'h06, 8'h5A);
    #1;
    chk("write_hit_busywait", 32'(BUSYWAIT), 32'd0);
    step();
    drive(1'b1, 1'b0, 8'h06, 8'h00);
    #1;
    chk("read_06_busywait",  32'(BUSYWAIT),  32'd0);
    chk("read_06_data",      32'(READDATA),  32'h5A);
    chk("read_06_mem_read",  32'(MEM_READ),  32'd0);
    chk("read_06_mem_write", 32'(MEM_WRITE), 32'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Dirty miss at 0x25 evicts block {0,1}.
    drive(1'b1, 1'b0, 8'h25, 8'h00);
    step();
    chk("wb_mem_write",     32'(MEM_WRITE),   32'd1);
    chk("wb_mem_read",      32'(MEM_READ),    32'd0);
    chk("wb_mem_address",   32'(MEM_ADDRESS), 32'h01);
    chk("wb_mem_writedata", MEM_WRITEDATA,    32'hDD5ABBAA);
    n = 0;
    while (!MEM_READ && n < 30) begin
      step();
      n++;
    end
    chk("refetch_mem_read",    32'(MEM_READ),    32'd1);
    chk("refetch_mem_address", 32'(MEM_ADDRESS), 32'h09);
    wait_ready("read_25", n);
    chk("read_25_data", 32'(READDATA), 32'h22);
    chk("writeback_landed", mem[1], 32'hDD5ABBAA);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset in the middle of a fetch.
    drive(1'b1, 1'b0, 8'h06, 8'h00);
    step();
    step();
    chk("pre_reset_mem_read", 32'(MEM_READ), 32'd1);
    RESET = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("rst_busywait",  32'(BUSYWAIT),  32'd0);
    chk("rst_mem_read",  32'(MEM_READ),  32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    step();
    RESET = 1'b0;
    step();
    drive(1'b1, 1'b0, 8'h06, 8'h00);
    #1;
    chk("reread_06_miss", 32'(BUSYWAIT), 32'd1);
    wait_ready("reread_06", n);
    chk("reread_06_data", 32'(READDATA), 32'h5A);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // READ and WRITE together are ignored.
    drive(1'b1, 1'b1, 8'h10, 8'hFF);
    #1;
    chk("both_busywait", 32'(BUSYWAIT), 32'd0);
    chk("both_readdata", 32'(READDATA), 32'd0);
    step();
    step();
    chk("both_mem_read",  32'(MEM_READ),  32'd0);
    chk("both_mem_write", 32'(MEM_WRITE), 32'd0);
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    chk("read_10_miss", 32'(BUSYWAIT), 32'd1);
    wait_ready("read_10", n);
    chk("read_10_data", 32'(READDATA), 32'h04);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Slow memory: busy for five cycles during the fetch.
    mem_lat = 5;
    drive(1'b1, 1'b0, 8'h40, 8'h00);
    step();
    n = 0;
    while (MEM_READ && n < 40) begin
      n++;
      step();
    end
    chk("slow_fetch_cycles", 32'(n), 32'd7);
    wait_ready("read_40", n);
    chk("read_40_data", 32'(READDATA), 32'h10);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Zero-latency memory: store miss, then evict the now-dirty block.
    mem_lat = 0;
    drive(1'b0, 1'b1, 8'h81, 8'h3C);
    #1;
    chk("write_81_miss", 32'(BUSYWAIT), 32'd1);
    wait_ready("write_81", n);
    chk("clean_miss_stall_fast", 32'(n), 32'd4);
    step();
    drive(1'b1, 1'b0, 8'h81, 8'h00);
    #1;
    chk("read_81_busywait", 32'(BUSYWAIT), 32'd0);
    chk("read_81_data",     32'(READDATA), 32'h3C);
    step();
    drive(1'b1, 1'b0, 8'h41, 8'h00);
    step();
    chk("wb2_mem_write",     32'(MEM_WRITE),   32'd1);
    chk("wb2_mem_address",   32'(MEM_ADDRESS), 32'h20);
    chk("wb2_mem_writedata", MEM_WRITEDATA,    32'h50403C20);
    wait_ready("read_41", n);
    chk("dirty_miss_stall_fast", 32'(n + 1), 32'd6);
    chk("read_41_data", 32'(READDATA), 32'h20);
    chk("writeback2_landed", mem[32], 32'h50403C20);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
